regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32: register data width.
REQ-002 Parameter ADDR_W, default 5: register address width; depth is 2**ADDR_W entries.
REQ-003 The block SHALL have one clock, and reset is asynchronous and active-low.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 we_i  in  1  writeback enable (driven by ALU reg_we_o).
REQ-007 waddr_i  in  ADDR_W  writeback address (ALU wr_addr_o).
REQ-008 wdata_i  in  DATA_W  writeback data (ALU rd_wdata_o).
REQ-009 raddr_a_i / raddr_b_i  in  ADDR_W  read addresses, rs1 / rs2.
REQ-010 rdata_a_o / rdata_b_o  out  DATA_W  read data, rs1 / rs2.
REQ-011 issue_i  in  1  decode issues an instruction that will write rd.
REQ-012 issue_addr_i  in  ADDR_W  rd of the issued instruction.
REQ-013 busy_a_o / busy_b_o  out  1  operand at raddr_a_i / raddr_b_i has a pending write.
REQ-014 stall_o  out  1  busy_a_o OR busy_b_o.

Function
REQ-015 The block SHALL register a write on a rising clk_i when we_i=1 and waddr_i!=0, storing wdata_i at waddr_i.
REQ-016 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0.
REQ-017 The read ports SHALL be combinational, with zero-cycle latency from raddr to rdata.
REQ-018 The block SHALL bypass same-cycle writes: if we_i=1 and waddr_i==raddr_x_i!=0, rdata_x_o SHALL equal wdata_i in that cycle.
REQ-019 Both read ports SHALL be independent and may address the same register.
REQ-020 Scoreboard: per register, a busy bit SHALL be set on a rising edge when issue_i=1 and issue_addr_i!=0.
REQ-021 The busy bit SHALL clear on a rising edge when we_i=1 and waddr_i matches the entry.
REQ-022 If set and clear hit the same entry in one edge, the set SHALL win and the bit SHALL stay 1.
REQ-023 Set and clear on different entries in the same edge SHALL both take effect.
REQ-024 busy_x_o SHALL be busy[raddr_x_i] AND NOT (we_i AND waddr_i==raddr_x_i), combinationally, so a same-cycle writeback never stalls.
REQ-025 Entry 0 SHALL never be busy, and issue to address 0 SHALL be ignored.
REQ-026 A write with we_i=1 to a non-busy register SHALL still update data, and its busy bit SHALL remain 0.
REQ-027 issue_i to an already-busy register SHALL keep the bit at 1; there is no counting, only the latest producer is tracked.
REQ-028 Inputs SHALL be sampled only on the rising clk_i; the design SHALL have no other state.

Reset
REQ-029 While rst_ni=0, all data entries SHALL be 0 and all busy bits 0, asynchronously.
REQ-030 Outputs during reset SHALL follow from that state: rdata 0 unless bypassing, busy 0, stall_o 0.
REQ-031 Reset asserted mid-operation SHALL drop pending writes and issues; the first edge after deassertion SHALL behave normally.

Structure
REQ-032 REG_NUM (32) and REG_ADDR_W (5) SHALL live in milano_pkg; parameter defaults SHALL derive from them.
REQ-033 The scoreboard SHALL be the sub-module regfile_scoreboard (inputs: issue/write/read addresses; outputs: busy_a/busy_b). Data storage stays in regfile.

Verification
REQ-034 Reset then read x1..x31 -> all rdata 0, stall_o 0.
REQ-035 Write x5=0xDEADBEEF; next cycle raddr_a=5 -> rdata_a_o=0xDEADBEEF; same cycle raddr_b=5 with we_i=1 -> bypass returns 0xDEADBEEF.
REQ-036 Write x0=0x12345678, then read x0 -> 0; issue_i to x0 -> busy 0.
REQ-037 Issue x7; next cycle raddr_a=7 -> busy_a_o=1 and stall_o=1; writeback x7=0x55 that cycle -> busy_a_o=0 combinationally; after the edge busy=0 and rdata=0x55.
REQ-038 Issue x9 and write x9 on the same edge -> busy[9]=1 afterwards, data=new wdata.
REQ-039 Issue x3, assert rst_ni=0 for 1 cycle mid-stream -> busy 0 and x3 = 0 after release.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared constants for the milano core register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: REG_NUM / REG_ADDR_W size the architectural register file,
//           REG_DATA_W is the default register width.
package milano_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: a bit is set on issue and cleared on writeback.
// Latency: busy bits update on the rising edge; busy_*_o is combinational from the read addresses.
// Backpressure: none; a same-cycle writeback masks its own busy bit so it never stalls.
// Ports: clk_i, rst_ni (async active-low); issue_i/issue_addr_i set a bit;
//        we_i/waddr_i clear a bit; raddr_a_i/raddr_b_i select busy_a_o/busy_b_o.
module regfile_scoreboard
  import milano_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear is applied before set so a same-edge issue to the entry being
  // written back keeps it busy: the new producer is the one tracked.
  always_comb begin
    busy_d = busy_q;
    if (we_i) begin
      busy_d[waddr_i] = 1'b0;
    end
    if (issue_i) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o = busy_q[raddr_a_i] & ~(we_i & (waddr_i == raddr_a_i));
  assign busy_b_o = busy_q[raddr_b_i] & ~(we_i & (waddr_i == raddr_b_i));

endmodule

// File: rtl/regfile.sv
// Two-read one-write register file with x0 hardwired to zero, write bypass and operand scoreboard.
// Latency: reads are combinational (zero cycles); writes land on the rising edge.
// Backpressure: stall_o flags a read operand still awaiting its writeback; the block never blocks writes.
// Ports: clk_i, rst_ni (async active-low); we_i/waddr_i/wdata_i writeback;
//        raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o; issue_i/issue_addr_i mark rd pending;
//        busy_a_o/busy_b_o per-operand pending flags, stall_o their OR.
module regfile
  import milano_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              stall_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // x0 reads as zero; otherwise a same-cycle write to the addressed entry
  // is forwarded so the consumer sees the value before it is stored.
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .busy_a_o     (busy_a_o),
    .busy_b_o     (busy_b_o)
  );

  assign stall_o = busy_a_o | busy_b_o;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a random phase.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic          busy_a;
  logic          busy_b;
  logic          stall;

  regfile #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .rdata_a_o    (rdata_a),
    .rdata_b_o    (rdata_b),
    .issue_i      (issue),
    .issue_addr_i (issue_addr),
    .busy_a_o     (busy_a),
    .busy_b_o     (busy_b),
    .stall_o      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ba;
    logic          bb;
    logic          st;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [NR];
  logic          mdl_busy [NR];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) begin
      mdl_mem[i]  = '0;
      mdl_busy[i] = 1'b0;
    end
  endtask

  // One cycle: drive at the falling edge, predict and check the combinational
  // outputs, then apply the edge to the model when out of reset.
  task automatic cyc(input string tag, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                     input logic [AW-1:0] rb, input logic iss,
                     input logic [AW-1:0] ia);
    exp_t e;
    exp_t o;
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    issue = iss; issue_addr = ia;
    e.a  = (ra == 0) ? '0 : ((w && wa == ra) ? wd : mdl_mem[ra]);
    e.b  = (rb == 0) ? '0 : ((w && wa == rb) ? wd : mdl_mem[rb]);
    e.ba = mdl_busy[ra] && !(w && wa == ra);
    e.bb = mdl_busy[rb] && !(w && wa == rb);
    e.st = e.ba || e.bb;
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    check({tag, ".rdata_a"}, rdata_a, o.a);
    check({tag, ".rdata_b"}, rdata_b, o.b);
    check({tag, ".busy_a"}, {31'd0, busy_a}, {31'd0, o.ba});
    check({tag, ".busy_b"}, {31'd0, busy_b}, {31'd0, o.bb});
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, o.st});
    @(posedge clk);
    if (rst_n) begin
      if (w && wa != 0) begin
        mdl_mem[wa]  = wd;
        mdl_busy[wa] = 1'b0;
      end
      if (iss && ia != 0) mdl_busy[ia] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    issue = 0; issue_addr = 0;
    rst_n = 1'b0;
    mdl_reset();
    repeat (2) @(negedge clk);
    cyc("in_reset", 0, 0, 0, 5'd1, 5'd31, 0, 0);
    rst_n = 1'b1;

    // All registers zero after reset, no stall.
    for (int i = 1; i < NR; i += 2) begin
      cyc("rst_read", 0, 0, 0, AW'(i), AW'(i + 1), 0, 0);
    end

    // Write, read back next cycle, and same-cycle bypass.
    cyc("wr_x5", 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 0);
    cyc("rd_x5", 0, 0, 0, 5'd5, 5'd5, 0, 0);
    cyc("byp_x5", 1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 0, 0);
    cyc("rd_x5b", 0, 0, 0, 5'd5, 5'd6, 0, 0);

    // x0 discards writes and never goes busy.
    cyc("wr_x0", 1, 5'd0, 32'h12345678, 5'd0, 5'd0, 0, 0);
    cyc("rd_x0", 0, 0, 0, 5'd0, 5'd0, 1, 5'd0);
    cyc("x0_busy", 0, 0, 0, 5'd0, 5'd0, 0, 0);

    // Issue x7, stall, writeback masks busy combinationally.
    cyc("iss_x7", 0, 0, 0, 5'd0, 5'd0, 1, 5'd7);
    cyc("stall_x7", 0, 0, 0, 5'd7, 5'd1, 0, 0);
    cyc("wb_x7", 1, 5'd7, 32'h55, 5'd7, 5'd7, 0, 0);
    cyc("post_x7", 0, 0, 0, 5'd7, 5'd7, 0, 0);

    // Set wins over clear on the same entry.
    cyc("iss_wr_x9", 1, 5'd9, 32'hA5A5_0009, 5'd0, 5'd0, 1, 5'd9);
    cyc("post_x9", 0, 0, 0, 5'd9, 5'd9, 0, 0);
    // Set and clear on different entries in one edge.
    cyc("iss10_wb9", 1, 5'd9, 32'h99, 5'd0, 5'd0, 1, 5'd10);
    cyc("post_9_10", 0, 0, 0, 5'd9, 5'd10, 0, 0);
    // Re-issue of an already busy register stays busy; one writeback clears it.
    cyc("reiss_x10", 0, 0, 0, 5'd0, 5'd0, 1, 5'd10);
    cyc("wb_x10", 1, 5'd10, 32'h1010, 5'd0, 5'd0, 0, 0);
    cyc("post_x10", 0, 0, 0, 5'd10, 5'd10, 0, 0);

    // Reset mid-stream drops pending state.
    cyc("wr_x3", 1, 5'd3, 32'h33, 5'd0, 5'd0, 1, 5'd3);
    cyc("busy_x3", 0, 0, 0, 5'd3, 5'd0, 1, 5'd4);
    rst_n = 1'b0;
    mdl_reset();
    cyc("mid_reset", 0, 0, 0, 5'd3, 5'd4, 1, 5'd3);
    rst_n = 1'b1;
    cyc("after_rst", 0, 0, 0, 5'd3, 5'd4, 0, 0);
    cyc("after_rst2", 1, 5'd3, 32'h77, 5'd3, 5'd5, 1, 5'd4);
    cyc("after_rst3", 0, 0, 0, 5'd3, 5'd4, 0, 0);

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 300; n++) begin
      cyc("rand", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
